usb_fifo_bridge: RTL and testbench

Sits between the 68008 glue-logic decoder and the FT245-style USB FIFO chip. It replaces direct CPU-strobed _rd/wr with buffered, timed transfers. An RX prefetch FIFO is filled from the chip whenever _rxf is low, and a TX FIFO is drained to the chip whenever _txe is low. The CPU sees single-cycle data-register accesses plus rx_avail/tx_space status bits and an active-low RX interrupt.

---
 rtl/usb_fifo_pkg.sv | 14 +
 rtl/sync_fifo.sv | 39 +++
 rtl/usb_fifo_bridge.sv | 111 +++++++++++
 tb/tb_usb_fifo_bridge.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_fifo_pkg.sv
// usb_fifo_pkg: transfer FSM states, round-robin markers and data width
// shared by usb_fifo_bridge and its FIFOs.
package usb_fifo_pkg;
   localparam int DATA_W = 8;
   localparam logic RR_RX = 1'b0;
   localparam logic RR_TX = 1'b1;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_STROBE,
      ST_WR_SETUP,
      ST_WR_STROBE,
      ST_RECOVER
   } state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers; pop on empty is ignored,
// push on full is dropped unless a pop frees the slot in the same cycle.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         empty,
   output logic         full
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic do_push, do_pop;
   always_comb begin
      empty    = wr_ptr_q == rd_ptr_q;
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
      head     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   always_ff @(posedge clk)
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
endmodule

// File: rtl/usb_fifo_bridge.sv
// usb_fifo_bridge: buffered CPU <-> FT245 bridge with RX prefetch and TX drain FIFOs.
// Define USB_LOOPBACK_EN to add the loopback input (TX drains straight into RX).
module usb_fifo_bridge
   import usb_fifo_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int RD_PULSE = 2,
   parameter int WR_PULSE = 2,
   parameter int RECOVER  = 1
) (
   input  logic              clk,
   input  logic              _reset,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              rx_avail,
   output logic              tx_space,
   output logic              _rx_irq,
`ifdef USB_LOOPBACK_EN
   input  logic              loopback,
`endif
   input  logic              _rxf,
   input  logic              _txe,
   output logic              _ft_rd,
   output logic              ft_wr,
   input  logic [DATA_W-1:0] ft_din,
   output logic [DATA_W-1:0] ft_dout,
   output logic              ft_doe
);
   logic rxf_m_q, rxf_s_q, txe_m_q, txe_s_q;
   state_e state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic rr_last_q, rr_last_d;
   logic lb_on, lb_act, rx_req, tx_req, take_tx;
   logic rx_push, tx_pop, rx_empty, rx_full, tx_empty, tx_full;
   logic [DATA_W-1:0] rx_din, rx_head, tx_head;
`ifdef USB_LOOPBACK_EN
   assign lb_on = loopback;
`else
   assign lb_on = 1'b0;
`endif
   always_ff @(posedge clk or negedge _reset)
      if (!_reset) begin
         {rxf_m_q, rxf_s_q, txe_m_q, txe_s_q} <= '1;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rr_last_q <= RR_RX;
      end else begin
         {rxf_s_q, rxf_m_q} <= {rxf_m_q, _rxf};
         {txe_s_q, txe_m_q} <= {txe_m_q, _txe};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rr_last_q <= rr_last_d;
      end
   // Loopback bypasses the chip entirely and keeps the FSM parked in IDLE.
   always_comb begin
      lb_act    = lb_on && state_q == ST_IDLE && !tx_empty && !rx_full;
      rx_req    = !rxf_s_q && !rx_full;
      tx_req    = !txe_s_q && !tx_empty;
      take_tx   = tx_req && (!rx_req || rr_last_q == RR_RX);
      state_d   = state_q;
      cnt_d     = cnt_q;
      rr_last_d = rr_last_q;
      rx_push   = lb_act;
      tx_pop    = lb_act;
      rx_din    = lb_act ? tx_head : ft_din;
      case (state_q)
         ST_IDLE:
            if (!lb_on && (rx_req || tx_req)) begin
               state_d = take_tx ? ST_WR_SETUP : ST_RD_STROBE;
               cnt_d   = take_tx ? 8'(WR_PULSE - 1) : 8'(RD_PULSE - 1);
            end
         ST_RD_STROBE:
            if (cnt_q == 8'd0) begin
               rx_push   = 1'b1;
               rr_last_d = RR_RX;
               state_d   = ST_RECOVER;
               cnt_d     = 8'(RECOVER - 1);
            end else cnt_d = cnt_q - 8'd1;
         ST_WR_SETUP: state_d = ST_WR_STROBE;
         ST_WR_STROBE:
            if (cnt_q == 8'd0) begin
               tx_pop    = 1'b1;
               rr_last_d = RR_TX;
               state_d   = ST_RECOVER;
               cnt_d     = 8'(RECOVER - 1);
            end else cnt_d = cnt_q - 8'd1;
         ST_RECOVER:
            if (cnt_q == 8'd0) state_d = ST_IDLE;
            else cnt_d = cnt_q - 8'd1;
         default: state_d = ST_IDLE;
      endcase
   end
   assign _ft_rd    = state_q != ST_RD_STROBE;
   assign ft_wr     = state_q == ST_WR_STROBE;
   assign ft_doe    = state_q == ST_WR_SETUP || state_q == ST_WR_STROBE;
   assign ft_dout   = ft_doe ? tx_head : '0;
   assign cpu_rdata = rx_head;
   assign rx_avail  = !rx_empty;
   assign _rx_irq   = rx_empty;
   assign tx_space  = !tx_full;
   sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rx (
      .clk(clk), .rst_n(_reset), .push(rx_push), .pop(cpu_rd), .din(rx_din),
      .head(rx_head), .empty(rx_empty), .full(rx_full)
   );
   sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_tx (
      .clk(clk), .rst_n(_reset), .push(cpu_wr), .pop(tx_pop), .din(cpu_wdata),
      .head(tx_head), .empty(tx_empty), .full(tx_full)
   );
endmodule

// File: tb/tb_usb_fifo_bridge.sv
// tb_usb_fifo_bridge: directed checks of usb_fifo_bridge with a small FT245 chip model.
// Loopback scenario runs only when USB_LOOPBACK_EN is defined.
module tb_usb_fifo_bridge;
   logic clk = 0, _reset = 0, cpu_rd = 0, cpu_wr = 0, _rxf = 1, _txe = 1;
   logic [7:0] cpu_wdata = 0, ft_din, cpu_rdata, ft_dout;
   logic rx_avail, tx_space, _rx_irq, _ft_rd, ft_wr, ft_doe;
`ifdef USB_LOOPBACK_EN
   logic loopback = 0;
`endif
   int compared = 0, mismatched = 0;
   logic [7:0] chip_rx [16];
   logic [7:0] rd_idx = 0;
   int rd_pulses = 0, doe_cycles = 0, unstable = 0, overlap = 0, seq_n = 0;
   logic [7:0] wr_log [$];
   logic seq [16];
   logic prev_doe = 0;
   logic [7:0] prev_dout = 0;

   always #5 clk = ~clk;
   assign ft_din = chip_rx[rd_idx[3:0]];

   usb_fifo_bridge dut (
      .clk(clk), ._reset(_reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .rx_avail(rx_avail), .tx_space(tx_space), ._rx_irq(_rx_irq),
`ifdef USB_LOOPBACK_EN
      .loopback(loopback),
`endif
      ._rxf(_rxf), ._txe(_txe), ._ft_rd(_ft_rd), .ft_wr(ft_wr), .ft_din(ft_din),
      .ft_dout(ft_dout), .ft_doe(ft_doe)
   );

   // Chip model: advance the RX byte after each read strobe, log written bytes and strobe order.
   always @(posedge _ft_rd) rd_idx <= rd_idx + 8'd1;
   always @(negedge _ft_rd) begin
      rd_pulses++;
      if (seq_n < 16) begin
         seq[seq_n] = 1'b1;
         seq_n++;
      end
   end
   always @(posedge ft_wr) begin
      wr_log.push_back(ft_dout);
      if (seq_n < 16) begin
         seq[seq_n] = 1'b0;
         seq_n++;
      end
   end
   always @(negedge clk) begin
      if (ft_doe && !_ft_rd) overlap++;
      if (ft_doe) doe_cycles++;
      if (ft_doe && prev_doe && ft_dout !== prev_dout) unstable++;
      prev_doe  <= ft_doe;
      prev_dout <= ft_dout;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      _reset = 0;
      tick(2);
      compared++;
      if ({_ft_rd, ft_wr, ft_doe} !== 3'b100) begin
         mismatched++;
         $display("FAIL reset_strobes: got %b want 100", {_ft_rd, ft_wr, ft_doe});
      end
      compared++;
      if (ft_dout !== 8'h00) begin
         mismatched++;
         $display("FAIL reset_dout: got %h want 00", ft_dout);
      end
      compared++;
      if (cpu_rdata !== 8'h00) begin
         mismatched++;
         $display("FAIL reset_rdata: got %h want 00", cpu_rdata);
      end
      compared++;
      if ({rx_avail, tx_space, _rx_irq} !== 3'b011) begin
         mismatched++;
         $display("FAIL reset_status: got %b want 011", {rx_avail, tx_space, _rx_irq});
      end
      _reset = 1;
      tick(2);
   endtask

   task automatic test_rx_pair;
      logic [11:0] rd_v, av_v;
      rd_idx = 0;
      _rxf = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         rd_v[i] = _ft_rd;
         av_v[i] = rx_avail;
         if (i == 6) _rxf = 1;
      end
      compared++;
      if (rd_v !== 12'hF33) begin
         mismatched++;
         $display("FAIL rx_pair_strobe: got %h want f33", rd_v);
      end
      compared++;
      if (av_v !== 12'hFF0) begin
         mismatched++;
         $display("FAIL rx_pair_avail: got %h want ff0", av_v);
      end
      compared++;
      if ({cpu_rdata, _rx_irq} !== {8'hA5, 1'b0}) begin
         mismatched++;
         $display("FAIL rx_pair_head1: got %h/%b want a5/0", cpu_rdata, _rx_irq);
      end
      cpu_rd = 1;
      tick();
      cpu_rd = 0;
      compared++;
      if (cpu_rdata !== 8'h5A) begin
         mismatched++;
         $display("FAIL rx_pair_head2: got %h want 5a", cpu_rdata);
      end
      cpu_rd = 1;
      tick();
      cpu_rd = 0;
      compared++;
      if ({rx_avail, _rx_irq, cpu_rdata} !== {2'b01, 8'h00}) begin
         mismatched++;
         $display("FAIL rx_pair_empty: got %b/%b/%h want 0/1/00", rx_avail, _rx_irq, cpu_rdata);
      end
   endtask

   task automatic test_rx_fill;
      rd_pulses = 0;
      _rxf = 0;
      tick(60);
      compared++;
      if (rd_pulses !== 8) begin
         mismatched++;
         $display("FAIL rx_fill_reads: got %0d want 8", rd_pulses);
      end
      compared++;
      if ({rx_avail, _ft_rd} !== 2'b11) begin
         mismatched++;
         $display("FAIL rx_fill_idle: got %b want 11", {rx_avail, _ft_rd});
      end
      rd_pulses = 0;
      cpu_rd = 1;
      tick();
      cpu_rd = 0;
      tick(20);
      compared++;
      if (rd_pulses !== 1) begin
         mismatched++;
         $display("FAIL rx_fill_refill: got %0d want 1", rd_pulses);
      end
      compared++;
      if (cpu_rdata !== 8'h33) begin
         mismatched++;
         $display("FAIL rx_fill_head: got %h want 33", cpu_rdata);
      end
      _rxf = 1;
      tick(4);
      for (int i = 0; i < 8; i++) begin
         cpu_rd = 1;
         tick();
      end
      cpu_rd = 0;
      compared++;
      if (rx_avail !== 1'b0) begin
         mismatched++;
         $display("FAIL rx_fill_drain: got %b want 0", rx_avail);
      end
   endtask

   task automatic test_tx_fill;
      for (int i = 0; i < 9; i++) begin
         cpu_wdata = 8'h11 + 8'(i);
         cpu_wr = 1;
         tick();
         if (i == 6) begin
            compared++;
            if (tx_space !== 1'b1) begin
               mismatched++;
               $display("FAIL tx_space_7: got %b want 1", tx_space);
            end
         end
         if (i == 7) begin
            compared++;
            if (tx_space !== 1'b0) begin
               mismatched++;
               $display("FAIL tx_space_8: got %b want 0", tx_space);
            end
         end
      end
      cpu_wr = 0;
      wr_log.delete();
      doe_cycles = 0;
      unstable = 0;
      _txe = 0;
      tick(60);
      compared++;
      if (wr_log.size() !== 8) begin
         mismatched++;
         $display("FAIL tx_count: got %0d want 8", wr_log.size());
      end
      for (int i = 0; i < 8; i++) begin
         compared++;
         if (wr_log[i] !== 8'h11 + 8'(i)) begin
            mismatched++;
            $display("FAIL tx_byte%0d: got %h want %h", i, wr_log[i], 8'h11 + 8'(i));
         end
      end
      compared++;
      if ({doe_cycles, unstable} !== {32'd24, 32'd0}) begin
         mismatched++;
         $display("FAIL tx_dout_stable: got %0d/%0d want 24/0", doe_cycles, unstable);
      end
      compared++;
      if (tx_space !== 1'b1) begin
         mismatched++;
         $display("FAIL tx_drained: got %b want 1", tx_space);
      end
   endtask

   task automatic test_alternate;
      _txe = 1;
      _rxf = 1;
      tick(3);
      for (int i = 0; i < 4; i++) begin
         cpu_wdata = 8'hC0 + 8'(i);
         cpu_wr = 1;
         tick();
      end
      cpu_wr = 0;
      seq_n = 0;
      overlap = 0;
      _rxf = 0;
      _txe = 0;
      tick(60);
      compared++;
      if ({seq[0], seq[1], seq[2], seq[3]} !== 4'b1010) begin
         mismatched++;
         $display("FAIL alt_order: got %b%b%b%b want 1010 (1=RD)", seq[0], seq[1], seq[2], seq[3]);
      end
      compared++;
      if (overlap !== 0) begin
         mismatched++;
         $display("FAIL alt_overlap: got %0d want 0", overlap);
      end
      _rxf = 1;
      tick(4);
      for (int i = 0; i < 8; i++) begin
         cpu_rd = 1;
         tick();
      end
      cpu_rd = 0;
   endtask

   task automatic test_reset_mid_write;
      _txe = 1;
      tick(3);
      for (int i = 0; i < 9; i++) begin
         cpu_wdata = 8'h40 + 8'(i);
         cpu_wr = 1;
         tick();
      end
      cpu_wr = 0;
      _txe = 0;
      for (int i = 0; i < 20 && !ft_wr; i++) tick();
      compared++;
      if ({ft_wr, tx_space} !== 2'b10) begin
         mismatched++;
         $display("FAIL midwr_pre: got wr/space %b want 10", {ft_wr, tx_space});
      end
      #2 _reset = 0;
      #1;
      compared++;
      if ({ft_wr, ft_doe, _ft_rd, ft_dout} !== {3'b001, 8'h00}) begin
         mismatched++;
         $display("FAIL midwr_strobes: got %b/%h want 001/00", {ft_wr, ft_doe, _ft_rd}, ft_dout);
      end
      compared++;
      if ({tx_space, rx_avail} !== 2'b10) begin
         mismatched++;
         $display("FAIL midwr_status: got %b want 10", {tx_space, rx_avail});
      end
      tick(2);
      _txe = 1;
      _reset = 1;
      tick(2);
   endtask

`ifdef USB_LOOPBACK_EN
   task automatic test_loopback;
      logic strobed;
      loopback = 1;
      _rxf = 0;
      rd_pulses = 0;
      wr_log.delete();
      tick(4);
      cpu_wdata = 8'h3C;
      cpu_wr = 1;
      tick();
      cpu_wr = 0;
      compared++;
      if (rx_avail !== 1'b0) begin
         mismatched++;
         $display("FAIL lb_early: got %b want 0", rx_avail);
      end
      tick();
      compared++;
      if ({rx_avail, cpu_rdata} !== {1'b1, 8'h3C}) begin
         mismatched++;
         $display("FAIL lb_data: got %b/%h want 1/3c", rx_avail, cpu_rdata);
      end
      strobed = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (!_ft_rd || ft_wr || ft_doe) strobed = 1;
      end
      compared++;
      if ({strobed, rd_pulses, wr_log.size()} !== {1'b0, 32'd0, 32'd0}) begin
         mismatched++;
         $display("FAIL lb_chip_idle: got %b/%0d/%0d want 0/0/0", strobed, rd_pulses, wr_log.size());
      end
      _rxf = 1;
      loopback = 0;
      tick(4);
   endtask
`endif

   initial begin
      for (int i = 0; i < 16; i++) chip_rx[i] = 8'h30 + 8'(i);
      chip_rx[0] = 8'hA5;
      chip_rx[1] = 8'h5A;
      test_reset();
      test_rx_pair();
      test_rx_fill();
      test_tx_fill();
      test_alternate();
      test_reset_mid_write();
`ifdef USB_LOOPBACK_EN
      test_loopback();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
